// File: rtl/router_pkg.sv
// Shared router definitions: header field layout, widths, reader state encoding.
// Used by the router FSM, FIFO and per-port packet readers.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR_CAP = 3'd1;
  localparam logic [2:0] S_PL_RD   = 3'd2;
  localparam logic [2:0] S_PL_CAP  = 3'd3;
  localparam logic [2:0] S_PAR_RD  = 3'd4;
  localparam logic [2:0] S_PAR_CAP = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    HDR_CAP = S_HDR_CAP,
    PL_RD   = S_PL_RD,
    PL_CAP  = S_PL_CAP,
    PAR_RD  = S_PAR_RD,
    PAR_CAP = S_PAR_CAP
  } state_t;

endpackage

// File: rtl/router_parity_chk.sv
// Packet parity accumulator: seeded by the header, XORs payload bytes,
// flags a mismatch against the trailing parity byte.
module router_parity_chk #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              accum,
  input  logic [DATA_W-1:0] data,
  output logic              bad
);

  logic [DATA_W-1:0] acc;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc <= '0;
    end else if (load) begin
      acc <= data;
    end else if (accum) begin
      acc <= acc ^ data;
    end
  end

  assign bad = (acc != data);

endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side reader of one router output FIFO: decodes header,
// streams payload to a host over valid/ready and checks packet parity.
module router_pkt_reader #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int LEN_W  = router_pkg::LEN_W,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  output logic              read_enb,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_last,
  input  logic              host_ready,
  output logic              pkt_start,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              pkt_abort
);

  import router_pkg::*;

  state_t            state;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  hdr_len;
  logic [ADDR_W-1:0] hdr_addr;
  logic              run;
  logic              accept;
  logic              par_bad;

  assign hdr_len  = data_out[LEN_MSB:LEN_LSB];
  assign hdr_addr = data_out[ADDR_MSB:ADDR_LSB];
  assign run      = resetn && !soft_reset;
  assign accept   = byte_valid && host_ready;

  // Payload reads wait for a free output slot so no byte is ever dropped.
  always_comb begin
    read_enb = 1'b0;
    if (run) begin
      case (state)
        IDLE:    read_enb = vld_out;
        PL_RD:   read_enb = vld_out && (!byte_valid || host_ready);
        PAR_RD:  read_enb = vld_out;
        default: read_enb = 1'b0;
      endcase
    end
  end

  router_parity_chk #(
    .DATA_W (DATA_W)
  ) u_parity (
    .clock  (clock),
    .resetn (resetn),
    .load   (run && state == HDR_CAP),
    .accum  (run && state == PL_CAP),
    .data   (data_out),
    .bad    (par_bad)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      rem        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_last  <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_len    <= '0;
      pkt_addr   <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
    end else if (soft_reset) begin
      state      <= IDLE;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_abort  <= (state != IDLE) || byte_valid;
    end else begin
      pkt_start <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      if (accept) begin
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (vld_out) state <= HDR_CAP;
        end
        HDR_CAP: begin
          pkt_len    <= hdr_len;
          pkt_addr   <= hdr_addr;
          rem        <= hdr_len;
          parity_err <= 1'b0;
          pkt_start  <= 1'b1;
          state      <= (hdr_len == '0) ? PAR_RD : PL_RD;
        end
        PL_RD: begin
          if (read_enb) state <= PL_CAP;
        end
        PL_CAP: begin
          byte_data  <= data_out;
          byte_valid <= 1'b1;
          byte_last  <= (rem == LEN_W'(1));
          rem        <= rem - LEN_W'(1);
          state      <= (rem == LEN_W'(1)) ? PAR_RD : PL_RD;
        end
        PAR_RD: begin
          if (read_enb) state <= PAR_CAP;
        end
        PAR_CAP: begin
          parity_err <= par_bad;
          pkt_done   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Scoreboard bench for router_pkt_reader: FIFO model feeds directed packets,
// a negedge monitor pops expected bytes/headers/status and compares.
module tb_router_pkt_reader;

  logic       clock;
  logic       resetn;
  logic       soft_reset;
  logic       vld_out;
  logic [7:0] data_out;
  logic       read_enb;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       host_ready;
  logic       pkt_start;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  logic       pkt_done;
  logic       parity_err;
  logic       pkt_abort;

  router_pkt_reader dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .host_ready (host_ready),
    .pkt_start  (pkt_start),
    .pkt_len    (pkt_len),
    .pkt_addr   (pkt_addr),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .pkt_abort  (pkt_abort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // FIFO model: registered read data, garbage when not read, flushed on resets
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign vld_out = (wr_ptr != rd_ptr);

  always @(posedge clock) begin
    if (!resetn || soft_reset) begin
      rd_ptr   <= wr_ptr;
      data_out <= 8'hEE;
    end else if (read_enb) begin
      data_out <= mem[rd_ptr % 256];
      rd_ptr   <= rd_ptr + 1;
    end else begin
      data_out <= 8'hEE;
    end
  end

  // Scoreboard queues
  int exp_b [$];
  int exp_h [$];
  int exp_e [$];
  int exp_abort = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  int start_t [$];
  int done_t  [$];

  always @(negedge clock) begin
    if (resetn) begin
      if (read_enb) rd_cnt++;
      if (byte_valid && host_ready) begin
        if (exp_b.size() == 0) chk("byte_extra", {byte_last, byte_data}, -1);
        else chk("byte", {byte_last, byte_data}, exp_b.pop_front());
      end
      if (pkt_start) begin
        start_t.push_back(cyc);
        chk("err_clr", parity_err, 0);
        if (exp_h.size() == 0) chk("hdr_extra", {pkt_len, pkt_addr}, -1);
        else chk("hdr", {pkt_len, pkt_addr}, exp_h.pop_front());
      end
      if (pkt_done) begin
        done_cnt++;
        done_t.push_back(cyc);
        if (exp_e.size() == 0) chk("done_extra", parity_err, -1);
        else chk("parity_err", parity_err, exp_e.pop_front());
      end
      if (pkt_abort) begin
        chk("abort_exp", int'(exp_abort > 0), 1);
        if (exp_abort > 0) exp_abort--;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] h, input logic [7:0] pl[$]);
    logic [7:0] x = h;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$],
                          input logic [7:0] par, input int err,
                          input int nacc, input bit complete);
    mem[wr_ptr % 256] = hdr;
    wr_ptr++;
    foreach (pl[i]) begin
      mem[wr_ptr % 256] = pl[i];
      wr_ptr++;
    end
    mem[wr_ptr % 256] = par;
    wr_ptr++;
    exp_h.push_back(int'(hdr));
    for (int i = 0; i < nacc; i++)
      exp_b.push_back({(i == pl.size() - 1), pl[i]});
    if (complete) exp_e.push_back(err);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 600) begin
      tick();
      k++;
    end
    chk("wait_done", int'(done_cnt >= n), 1);
  endtask

  task automatic wait_byte(input logic [7:0] v);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!(byte_valid && byte_data == v) && k < 300);
    chk("wait_byte", int'(byte_valid && byte_data == v), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] pl3 [$];
  logic [7:0] pl5 [$];
  logic [7:0] pl2 [$];
  logic [7:0] pl4 [$];
  logic [7:0] none [$];
  logic [7:0] pa [$];
  logic [7:0] pb [$];
  int r0;
  int s0;
  int d0;

  initial begin
    resetn     = 1'b0;
    soft_reset = 1'b0;
    host_ready = 1'b1;
    pl3 = '{8'h11, 8'h22, 8'h33};
    pl5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pl2 = '{8'hA1, 8'hB2};
    pl4 = '{8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 63; i++) begin
      pa.push_back(8'(i + 1));
      pb.push_back(8'(8'h80 + i));
    end
    repeat (3) tick();
    chk("rst_outs", {read_enb, byte_valid, byte_last, pkt_start, pkt_done,
                     parity_err, pkt_abort, byte_data, pkt_len, pkt_addr}, 0);
    resetn = 1'b1;
    tick();

    // basic packet, good parity
    r0 = rd_cnt;
    send_pkt(8'h0E, pl3, 8'h0E, 0, 3, 1);
    wait_done(1);
    chk("t1_reads", rd_cnt - r0, 5);
    chk("t1_len", pkt_len, 3);
    chk("t1_addr", pkt_addr, 2);

    // bad parity, held until next header
    send_pkt(8'h0E, pl3, 8'h0F, 1, 3, 1);
    wait_done(2);
    repeat (5) tick();
    chk("t2_err_held", parity_err, 1);

    // host stall on 0x22
    send_pkt(8'h0E, pl3, 8'h0E, 0, 3, 1);
    wait_byte(8'h22);
    host_ready = 1'b0;
    repeat (10) begin
      tick();
      chk("t3_stall_rd", read_enb, 0);
      chk("t3_stall_hold", {byte_valid, byte_data}, 9'h122);
    end
    host_ready = 1'b1;
    wait_done(3);

    // soft reset during byte 2 of a len=5 packet
    send_pkt(8'h14, pl5, xsum(8'h14, pl5), 0, 1, 0);
    wait_byte(8'h02);
    host_ready = 1'b0;
    soft_reset = 1'b1;
    exp_abort  = 1;
    tick();
    soft_reset = 1'b0;
    host_ready = 1'b1;
    chk("t4_abort", pkt_abort, 1);
    chk("t4_bv_clr", byte_valid, 0);
    chk("t4_len_kept", pkt_len, 5);
    send_pkt(8'h09, pl2, 8'h1A, 0, 2, 1);
    wait_done(4);
    chk("t4_len", pkt_len, 2);
    chk("t4_addr", pkt_addr, 1);

    // zero-length packet
    send_pkt(8'h01, none, 8'h01, 0, 0, 1);
    wait_done(5);
    chk("t5_len", pkt_len, 0);

    // hard reset mid-payload
    send_pkt(8'h10, pl4, xsum(8'h10, pl4), 0, 0, 0);
    wait_byte(8'h05);
    resetn     = 1'b0;
    host_ready = 1'b0;
    #1;
    chk("t6_rd_in_rst", read_enb, 0);
    tick();
    chk("t6_rst_outs", {read_enb, byte_valid, byte_last, pkt_start, pkt_done,
                        parity_err, pkt_abort, byte_data, pkt_len, pkt_addr}, 0);
    tick();
    resetn     = 1'b1;
    host_ready = 1'b1;
    chk("t6_no_pending", exp_b.size(), 0);

    // two back-to-back maximum-length packets
    s0 = start_t.size();
    d0 = done_t.size();
    send_pkt(8'hFC, pa, xsum(8'hFC, pa), 0, 63, 1);
    send_pkt(8'hFF, pb, xsum(8'hFF, pb), 0, 63, 1);
    wait_done(7);
    if (start_t.size() >= s0 + 2 && done_t.size() >= d0 + 2) begin
      chk("t6_start_gap", start_t[s0+1] - start_t[s0], 130);
      chk("t6_done_gap", done_t[d0+1] - done_t[d0], 130);
    end else begin
      chk("t6_pulses", start_t.size() - s0, 2);
    end
    repeat (4) tick();

    chk("end_bytes", exp_b.size(), 0);
    chk("end_hdrs", exp_h.size(), 0);
    chk("end_errs", exp_e.size(), 0);
    chk("end_abort", exp_abort, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
